// File: rtl/router_pkg.sv
// router_pkg: constants, types and FSM state encodings shared by the router FSM and datapath.
`default_nettype none

package router_pkg;

  localparam int DATA_W = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef logic [DATA_W-1:0] byte_t;

  // Router FSM state encodings, shared with fsm_router
  localparam logic [2:0] DECODE_ADDRESS     = 3'b000;
  localparam logic [2:0] LOAD_FIRST_DATA    = 3'b001;
  localparam logic [2:0] LOAD_DATA          = 3'b010;
  localparam logic [2:0] LOAD_PARITY        = 3'b011;
  localparam logic [2:0] CHECK_PARITY_ERROR = 3'b100;
  localparam logic [2:0] FIFO_FULL_STATE    = 3'b101;
  localparam logic [2:0] WAIT_TILL_EMPTY    = 3'b110;
  localparam logic [2:0] LOAD_AFTER_FULL    = 3'b111;

  function automatic logic addr_valid(input logic [1:0] addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

`default_nettype wire

// File: rtl/router_parity_chk.sv
// router_parity_chk: running packet parity, received parity byte and mismatch flag.
`default_nettype none

module router_parity_chk
  import router_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  detect_addr,
  input  logic  lfd_state,
  input  logic  ld_state,
  input  logic  full_state,
  input  logic  pkt_valid,
  input  logic  parity_done,
  input  byte_t hdr_byte,
  input  byte_t data_in,
  output logic  err
);

  byte_t int_parity;
  byte_t pkt_parity;

  // A byte parked on a full FIFO is counted here in LOAD_DATA, so the
  // later LOAD_AFTER_FULL replay must not add it again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_parity <= '0;
    end else if (detect_addr) begin
      int_parity <= '0;
    end else if (lfd_state) begin
      int_parity <= int_parity ^ hdr_byte;
    end else if (ld_state && pkt_valid && !full_state) begin
      int_parity <= int_parity ^ data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_parity <= '0;
    end else if (detect_addr) begin
      pkt_parity <= '0;
    end else if (!lfd_state && ld_state && !pkt_valid) begin
      pkt_parity <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (detect_addr) begin
      err <= 1'b0;
    end else if (parity_done) begin
      err <= (int_parity != pkt_parity);
    end
  end

endmodule

`default_nettype wire

// File: rtl/router_reg.sv
// router_reg: header latch, FIFO write-bus steering with one-byte full parking, FSM handshake flags.
`default_nettype none

module router_reg
  import router_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  pkt_valid,
  input  byte_t data_in,
  input  logic  fifo_full,
  input  logic  detect_addr,
  input  logic  lfd_state,
  input  logic  ld_state,
  input  logic  laf_state,
  input  logic  full_state,
  input  logic  rst_int_reg,
  output byte_t dout,
  output logic  parity_done,
  output logic  low_pkt_valid,
  output logic  err
);

  byte_t hdr_byte;
  byte_t full_byte;

  logic ld_act;
  logic laf_act;

  // lfd outranks ld, which outranks laf
  assign ld_act  = ld_state && !lfd_state;
  assign laf_act = laf_state && !lfd_state && !ld_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_byte <= '0;
    end else if (detect_addr && pkt_valid && addr_valid(data_in[1:0])) begin
      hdr_byte <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout      <= '0;
      full_byte <= '0;
    end else if (lfd_state) begin
      dout <= hdr_byte;
    end else if (ld_act && !fifo_full) begin
      dout <= data_in;
    end else if (ld_act && fifo_full) begin
      full_byte <= data_in;
    end else if (laf_act) begin
      dout <= full_byte;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  // Parity byte either goes straight out in LOAD_DATA or is replayed from
  // full_byte in LOAD_AFTER_FULL once the FIFO drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_done <= 1'b0;
    end else if (detect_addr) begin
      parity_done <= 1'b0;
    end else if ((ld_act && !fifo_full && !pkt_valid) ||
                 (laf_act && low_pkt_valid && !parity_done)) begin
      parity_done <= 1'b1;
    end
  end

  router_parity_chk u_parity_chk (
    .clk         (clk),
    .rst         (rst),
    .detect_addr (detect_addr),
    .lfd_state   (lfd_state),
    .ld_state    (ld_state),
    .full_state  (full_state),
    .pkt_valid   (pkt_valid),
    .parity_done (parity_done),
    .hdr_byte    (hdr_byte),
    .data_in     (data_in),
    .err         (err)
  );

endmodule

`default_nettype wire

// File: tb/tb_router_reg.sv
// tb_router_reg: directed self-checking bench for router_reg.
`default_nettype none

module tb_router_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_addr;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;

  int n_pass  = 0;
  int n_total = 0;

  router_reg dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_addr   (detect_addr),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // strobe order: detect, lfd, ld, laf, full, rst_int
  task automatic drv(input logic [5:0] s, input logic pv, input logic ff, input logic [7:0] d);
    {detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = s;
    pkt_valid = pv;
    fifo_full = ff;
    data_in   = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RINT = 6'b000001;

  initial begin
    rst = 1'b0;
    drv(S_NONE, 1'b0, 1'b0, 8'h00);
    #12;
    chk("reset_dout", dout, 8'h00);
    chk("reset_pd", {7'd0, parity_done}, 8'h00);
    chk("reset_lpv", {7'd0, low_pkt_valid}, 8'h00);
    chk("reset_err", {7'd0, err}, 8'h00);
    rst = 1'b1;

    // Normal packet: 0D, A5, 3C, parity 94
    drv(S_DA, 1'b1, 1'b0, 8'h0D);  step();
    drv(S_LFD, 1'b1, 1'b0, 8'hA5); step();
    chk("p1_hdr", dout, 8'h0D);
    drv(S_LD, 1'b1, 1'b0, 8'hA5);  step();
    chk("p1_d0", dout, 8'hA5);
    drv(S_LD, 1'b1, 1'b0, 8'h3C);  step();
    chk("p1_d1", dout, 8'h3C);
    chk("p1_pd_low", {7'd0, parity_done}, 8'h00);
    drv(S_LD, 1'b0, 1'b0, 8'h94);  step();
    chk("p1_par", dout, 8'h94);
    chk("p1_pd", {7'd0, parity_done}, 8'h01);
    chk("p1_lpv", {7'd0, low_pkt_valid}, 8'h01);
    drv(S_NONE, 1'b0, 1'b0, 8'h00); step();
    chk("p1_err", {7'd0, err}, 8'h00);

    // rst_int_reg clears only low_pkt_valid
    drv(S_RINT, 1'b0, 1'b0, 8'h00); step();
    chk("rint_lpv", {7'd0, low_pkt_valid}, 8'h00);
    chk("rint_dout", dout, 8'h94);
    chk("rint_pd", {7'd0, parity_done}, 8'h01);
    chk("rint_err", {7'd0, err}, 8'h00);

    // Bad parity packet
    drv(S_DA, 1'b1, 1'b0, 8'h0D);  step();
    drv(S_LFD, 1'b1, 1'b0, 8'hA5); step();
    drv(S_LD, 1'b1, 1'b0, 8'hA5);  step();
    drv(S_LD, 1'b1, 1'b0, 8'h3C);  step();
    drv(S_LD, 1'b0, 1'b0, 8'h00);  step();
    chk("p2_par", dout, 8'h00);
    chk("p2_pd", {7'd0, parity_done}, 8'h01);
    drv(S_NONE, 1'b0, 1'b0, 8'h00); step();
    chk("p2_err", {7'd0, err}, 8'h01);
    drv(S_RINT, 1'b0, 1'b0, 8'h00); step();
    chk("p2_err_hold", {7'd0, err}, 8'h01);

    // Full stall packet: 0E, 11, 5A (parked), parity 45 (parked)
    drv(S_DA, 1'b1, 1'b0, 8'h0E);  step();
    chk("p3_da_err_clr", {7'd0, err}, 8'h00);
    chk("p3_da_pd_clr", {7'd0, parity_done}, 8'h00);
    drv(S_LFD, 1'b1, 1'b0, 8'h11); step();
    chk("p3_hdr", dout, 8'h0E);
    drv(S_LD, 1'b1, 1'b0, 8'h11);  step();
    chk("p3_d0", dout, 8'h11);
    drv(S_LD, 1'b1, 1'b1, 8'h5A);  step();
    chk("p3_full_hold", dout, 8'h11);
    drv(S_FULL, 1'b1, 1'b1, 8'h5A); step();
    chk("p3_fs_hold", dout, 8'h11);
    drv(S_LAF, 1'b1, 1'b0, 8'h5A); step();
    chk("p3_laf_data", dout, 8'h5A);
    chk("p3_laf_pd", {7'd0, parity_done}, 8'h00);
    drv(S_LD, 1'b0, 1'b1, 8'h45);  step();
    chk("p3_par_park", dout, 8'h5A);
    chk("p3_par_lpv", {7'd0, low_pkt_valid}, 8'h01);
    chk("p3_par_pd", {7'd0, parity_done}, 8'h00);
    drv(S_FULL, 1'b0, 1'b1, 8'h45); step();
    drv(S_LAF, 1'b0, 1'b0, 8'h45); step();
    chk("p3_laf_par", dout, 8'h45);
    chk("p3_laf_pd_set", {7'd0, parity_done}, 8'h01);
    drv(S_NONE, 1'b0, 1'b0, 8'h00); step();
    chk("p3_err", {7'd0, err}, 8'h00);

    // Invalid address keeps the old header 0E
    drv(S_DA, 1'b1, 1'b0, 8'h07);  step();
    drv(S_LFD, 1'b1, 1'b0, 8'h07); step();
    chk("inv_hdr", dout, 8'h0E);
    drv(S_LD, 1'b0, 1'b0, 8'h33);  step();
    chk("inv_par", dout, 8'h33);
    chk("inv_pd", {7'd0, parity_done}, 8'h01);
    drv(S_LD, 1'b1, 1'b0, 8'h77);  step();
    chk("inv_d", dout, 8'h77);
    chk("inv_err", {7'd0, err}, 8'h01);

    // Asynchronous reset mid-packet, checked before the next edge
    #2 rst = 1'b0;
    #1;
    chk("arst_dout", dout, 8'h00);
    chk("arst_pd", {7'd0, parity_done}, 8'h00);
    chk("arst_lpv", {7'd0, low_pkt_valid}, 8'h00);
    chk("arst_err", {7'd0, err}, 8'h00);
    #2 rst = 1'b1;
    drv(S_LD, 1'b1, 1'b0, 8'h99);  step();
    chk("post_rst_d", dout, 8'h99);
    drv(S_LFD, 1'b1, 1'b0, 8'h99); step();
    chk("post_rst_hdr", dout, 8'h00);

    drv(S_NONE, 1'b0, 1'b0, 8'h00); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
